// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// the latched request record and the funct3 legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Only the fields needed after accept are kept; the word index lives in mem_addr.
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  // Unsigned sub-word variants exist for loads only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: merges store data into a memory word and
// extracts/extends load data from it.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_data_o
);

  logic [3:0][7:0] word_b;
  logic [3:0][7:0] src_b;
  logic [3:0][7:0] merged_b;
  logic [3:0]      be;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign word_b = word_i;

  // Replicate the store data across lanes and pick the lane enables from size/offset.
  always_comb begin
    be    = 4'b1111;
    src_b = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be    = 4'b0001 << off_i;
        src_b = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be    = off_i[1] ? 4'b1100 : 4'b0011;
        src_b = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_b[i] = be[i] ? src_b[i] : word_b[i];
  end

  assign st_word_o = merged_b;
  assign ld_byte   = word_b[off_i];
  assign ld_half   = off_i[1] ? word_i[31:16] : word_i[15:0];

  // Sign- or zero-extend the selected lane; full word passes through.
  always_comb begin
    ld_data_o = word_i;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores via read-modify-write,
// faults reported without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;

  logic        acc;
  logic        misalign;
  logic        range_err;
  logic        acc_err;
  logic [31:0] st_word;
  logic [31:0] ld_data;

  lsu_align u_align (
    .word_i    (mem_rdata),
    .off_i     (req_q.off),
    .funct3_i  (req_q.funct3),
    .wdata_i   (req_q.wdata),
    .st_word_o (st_word),
    .ld_data_o (ld_data)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign acc       = req_valid && req_ready;

  assign misalign  = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign range_err = {1'b0, req_addr} >= ADDR_LIMIT;
  assign acc_err   = misalign || range_err || !f3_legal(req_we, req_funct3);

  // Next-state and output register logic; mem_addr/mem_wdata only move on real accesses.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          req_d = '{we: req_we, funct3: req_funct3, off: req_addr[1:0], wdata: req_wdata};
          if (acc_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_addr_d = {2'b00, req_addr[31:2]};
            if (req_we && (req_funct3 == F3_W)) begin
              state_d     = ST_WRITE;
              mem_wdata_d = req_wdata;
              mem_we_d    = 1'b1;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (req_q.we) begin
          state_d     = ST_WRITE;
          mem_wdata_d = st_word;
          mem_we_d    = 1'b1;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ld_data;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; async reset also kills an in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory stage and the word-wide, single-port data memory. The data memory is word-indexed, has a combinational read and a full-word write on posedge.
- Accepts one load/store request at a time over a valid/ready handshake.
- Sub-word stores are done as read-modify-write; loads are extracted and sign/zero-extended.
- Misaligned, out-of-range and illegal accesses are flagged without touching memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data memory. Byte addresses at or above 4*DEPTH_WORDS are out of range.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle response pulse, no backpressure
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  access fault, qualified by rsp_valid
- mem_addr  output  32  word index to data memory = req_addr[31:2]
- mem_wdata  output  32  full word to write
- mem_we  output  1  data memory write enable
- mem_rdata  input  32  combinational read data from data memory

Behaviour:
- Reset values (asynchronous): state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_we 0, mem_addr 0, mem_wdata 0. req_ready is 1 while in IDLE.
- Handshake: accept on the rising edge where req_valid && req_ready. addr, we, funct3 and wdata are latched at that edge. Inputs are ignored outside IDLE.
- Error check at accept; error if any of:
  - H access with addr[0] != 0, or W access with addr[1:0] != 0
  - addr >= 4*DEPTH_WORDS
  - funct3 not in the legal set (includes store with 100/101, any 011/110/111)
- States: IDLE, READ, WRITE, RESP.
- Transitions from IDLE on accept:
  - error -> RESP with err=1
  - load -> READ
  - SW -> WRITE
  - SB/SH -> READ
- READ:
  - drive mem_addr, mem_we=0, and register mem_rdata at the end of the cycle
  - load -> RESP; SB/SH -> WRITE
- WRITE:
  - mem_we=1 for exactly one cycle; memory updates on the closing edge; -> RESP
  - mem_wdata = wdata for SW, or the read word with the target lane(s) replaced for SB/SH
- RESP: rsp_valid=1 for one cycle -> IDLE.
- Latency, counted from the accept edge to the cycle rsp_valid is high:
  - error: 1
  - load: 2
  - SW: 2
  - SB/SH: 3
- Lanes:
  - B uses byte lane addr[1:0]; SB writes req_wdata[7:0] into that lane.
  - H uses halfword lane addr[1]; SH writes req_wdata[15:0] into that lane.
  - Untouched lanes are preserved bit-exact.
- Loads:
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word unchanged.
- Outputs in IDLE/RESP: mem_we=0 and mem_addr holds its last value. On an error path, mem_we is never asserted.
- Reset mid-operation: rst_n low forces IDLE immediately and mem_we drops combinationally, so an interrupted RMW leaves the memory word unchanged. No response is produced for the aborted request.
- A request held high across a response is accepted again in the cycle after RESP (it is treated as a new request).

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum.
- Sub-module lsu_align (combinational):
  - given the word, addr[1:0], funct3 and store data, produces the merged store word and the extended load value
  - unit-testable on its own

Test Plan:
- Preload word 28 = 0x00000020; LW addr 0x70 -> rsp_valid at accept+2, rsp_rdata 0x00000020, rsp_err 0, mem_we never high.
- Preload word 40 = 0x00000002; SB addr 0xA1 data 0x123456FF -> mem_we high once at accept+2, word 40 = 0x0000FF02, rsp at accept+3. Then LB 0xA1 -> 0xFFFFFFFF and LBU 0xA1 -> 0x000000FF.
- SH addr 0x72 data 0x00008001 with word 28 = 0x00000020 -> word 28 = 0x80010020. Then LH 0x72 -> 0xFFFF8001, LHU 0x72 -> 0x00008001, SW 0x70 0xDEADBEEF then LW 0x70 -> 0xDEADBEEF.
- Error cases, each -> rsp_valid and rsp_err at accept+1, rsp_rdata 0, mem_we 0, memory unchanged:
  - LW 0x71
  - SH 0x73
  - LW 0x1000
  - store with funct3 100
- Reset during the WRITE cycle of SB 0xA0 data 0x55 (word 40 = 0x00000002) -> mem_we falls at once, word 40 stays 0x00000002, no rsp_valid, req_ready 1 after rst_n rises.
- req_valid held high with two queued requests -> req_ready low from accept until RESP completes; the second request is accepted the cycle after rsp_valid; responses arrive in order.
